// File: rtl/rr_rsp_router.sv
// rr_rsp_router: routes in-order downstream responses back to the port whose grant
// was recorded in a tag FIFO, via a one-entry output register with back-to-back reload.
module rr_rsp_router #(
    parameter int PORT_NUM   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_vld,
    input  logic [$clog2(PORT_NUM)-1:0]  issue_port,
    output logic                         issue_rdy,
    input  logic                         rsp_vld,
    input  logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_rdy,
    output logic [PORT_NUM-1:0]          port_vld,
    output logic [DATA_WIDTH-1:0]        port_data,
    input  logic [PORT_NUM-1:0]          port_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_ovf
);
    localparam int PW = $clog2(PORT_NUM);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         fifo_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         out_port_q, out_port_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic                  full, hold, out_rdy, push, pop;

    // Readiness depends on registered state only; port_rdy feeds rsp_rdy alone.
    always_comb begin
        full        = (cnt_q == CW'(DEPTH));
        hold        = (state_q == HOLD);
        out_rdy     = port_rdy[out_port_q];
        issue_rdy   = !full;
        rsp_rdy     = (cnt_q != '0) && (!hold || out_rdy);
        push        = issue_vld && !full;
        pop         = rsp_vld && rsp_rdy;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        err_d       = err_q || (issue_vld && full);
        state_d     = pop ? HOLD : (hold && out_rdy) ? IDLE : state_q;
        out_port_d  = pop ? fifo_q[rd_ptr_q] : out_port_q;
        data_d      = pop ? rsp_data : data_q;
        port_vld    = hold ? (PORT_NUM'(1) << out_port_q) : '0;
        port_data   = data_q;
        outstanding = cnt_q + CW'(hold);
        err_ovf     = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            out_port_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            out_port_q <= out_port_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= issue_port;
    end
endmodule

// File: tb/tb_rr_rsp_router.sv
// tb_rr_rsp_router: directed stimulus with a scoreboard of expected port deliveries,
// checked by an independent monitor on every port handshake.
module tb_rr_rsp_router;
    logic        clk = 0;
    logic        rst = 1;
    logic        issue_vld = 0;
    logic [3:0]  issue_port = 0;
    logic        issue_rdy;
    logic        rsp_vld = 0;
    logic [31:0] rsp_data = 0;
    logic        rsp_rdy;
    logic [15:0] port_vld;
    logic [31:0] port_data;
    logic [15:0] port_rdy = 16'hFFFF;
    logic [3:0]  outstanding;
    logic        err_ovf;

    int vectors = 0;
    int miscompares = 0;
    logic [47:0] exp_q [$];

    rr_rsp_router dut (
        .clk(clk), .rst(rst),
        .issue_vld(issue_vld), .issue_port(issue_port), .issue_rdy(issue_rdy),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
        .port_vld(port_vld), .port_data(port_data), .port_rdy(port_rdy),
        .outstanding(outstanding), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [3:0] p);
        issue_vld = 1;
        issue_port = p;
        tick();
        issue_vld = 0;
    endtask

    task automatic rsp(input logic [31:0] d, input logic [15:0] ev);
        rsp_vld = 1;
        rsp_data = d;
        #1 chk("rsp_rdy", 32'(rsp_rdy), 1);
        exp_q.push_back({ev, d});
        tick();
        rsp_vld = 0;
    endtask

    // Monitor: every port handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (port_vld & port_rdy) != 0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: port_vld %h data %h", port_vld, port_data);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("mon_port_vld", 32'(port_vld), 32'(e[47:32]));
                chk("mon_port_data", port_data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_issue_rdy", 32'(issue_rdy), 1);
        chk("rst_rsp_rdy", 32'(rsp_rdy), 0);
        chk("rst_port_vld", 32'(port_vld), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        tick();
        rst = 0;
        tick();

        // Single round trip
        issue(5);
        chk("t1_out_a", 32'(outstanding), 1);
        rsp(32'hA5A5_0001, 16'h0020);
        chk("t1_port_vld", 32'(port_vld), 32'h0020);
        chk("t1_out_b", 32'(outstanding), 1);
        tick();
        chk("t1_out_c", 32'(outstanding), 0);
        chk("t1_idle_vld", 32'(port_vld), 0);

        // In-order routing, back to back
        issue(3); issue(0); issue(15); issue(3);
        chk("t2_out", 32'(outstanding), 4);
        rsp(32'hD000_0000, 16'h0008);
        rsp(32'hD000_0001, 16'h0001);
        chk("t2_vld1", 32'(port_vld), 32'h0001);
        rsp(32'hD000_0002, 16'h8000);
        rsp(32'hD000_0003, 16'h0008);
        chk("t2_vld3", 32'(port_vld), 32'h0008);
        idle(2);

        // Backpressure on port 7 while port 2's response waits
        issue(7); issue(2);
        rsp(32'hBEEF_0007, 16'h0080);
        port_rdy = ~16'h0080;
        rsp_vld = 1;
        rsp_data = 32'hBEEF_0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_vld", 32'(port_vld), 32'h0080);
            chk("t3_hold_data", port_data, 32'hBEEF_0007);
            chk("t3_rsp_rdy", 32'(rsp_rdy), 0);
            tick();
        end
        port_rdy = 16'hFFFF;
        #1 chk("t3_release_rdy", 32'(rsp_rdy), 1);
        exp_q.push_back({16'h0004, 32'hBEEF_0002});
        tick();
        rsp_vld = 0;
        chk("t3_next_vld", 32'(port_vld), 32'h0004);
        idle(2);

        // Full and overflow
        for (int i = 0; i < 8; i++) issue(4'(i));
        chk("t4_full_rdy", 32'(issue_rdy), 0);
        chk("t4_full_out", 32'(outstanding), 8);
        issue(9);
        chk("t4_err", 32'(err_ovf), 1);
        chk("t4_ovf_out", 32'(outstanding), 8);
        for (int i = 0; i < 8; i++) rsp(32'h100 + 32'(i), 16'(1 << i));
        idle(2);
        chk("t4_drain_rdy", 32'(issue_rdy), 1);
        chk("t4_err_sticky", 32'(err_ovf), 1);
        chk("t4_drain_out", 32'(outstanding), 0);

        // Empty stall, then simultaneous push/pop across pointer wrap
        rsp_vld = 1;
        rsp_data = 32'hEEEE_EEEE;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t5_empty_rdy", 32'(rsp_rdy), 0);
            tick();
            chk("t5_empty_vld", 32'(port_vld), 0);
        end
        rsp_vld = 0;
        issue(9); issue(10);
        chk("t5_out2", 32'(outstanding), 2);
        issue_vld = 1;
        issue_port = 11;
        rsp_vld = 1;
        rsp_data = 32'h5555_0009;
        #1 chk("t5_pp_rdy", 32'(rsp_rdy), 1);
        exp_q.push_back({16'h0200, 32'h5555_0009});
        tick();
        issue_vld = 0;
        rsp_vld = 0;
        chk("t5_pp_out", 32'(outstanding), 3);
        rsp(32'h5555_000A, 16'h0400);
        rsp(32'h5555_000B, 16'h0800);
        idle(2);
        chk("t5_end_out", 32'(outstanding), 0);

        // Asynchronous reset mid-drain
        issue(2); issue(5); issue(6); issue(8);
        port_rdy = ~16'h0004;
        rsp(32'hDEAD_0002, 16'h0004);
        chk("t6_pre_vld", 32'(port_vld), 32'h0004);
        chk("t6_pre_out", 32'(outstanding), 4);
        #2 rst = 1;
        #1;
        chk("t6_rst_vld", 32'(port_vld), 0);
        chk("t6_rst_data", port_data, 0);
        chk("t6_rst_out", 32'(outstanding), 0);
        chk("t6_rst_issue_rdy", 32'(issue_rdy), 1);
        chk("t6_rst_rsp_rdy", 32'(rsp_rdy), 0);
        chk("t6_rst_err", 32'(err_ovf), 0);
        exp_q.delete();
        tick();
        rst = 0;
        port_rdy = 16'hFFFF;
        tick();
        issue(1);
        rsp(32'h0000_1111, 16'h0002);
        idle(2);
        chk("t6_final_out", 32'(outstanding), 0);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_rsp_router.md
Name: rr_rsp_router

Overview:
- Return path paired with the round-robin request arbiter. The arbiter merges PORT_NUM requesters onto one downstream channel; this block routes the in-order responses on that channel back to the port that issued each request.
- On every accepted arbitration, the granted port index is pushed into an in-order tag FIFO.
- Each downstream response pops the head tag and is presented, through a one-entry output register, to that port only.

Parameters:
- PORT_NUM, 16, number of requester ports; must be ≥2.
- DATA_WIDTH, 32, response payload width.
- DEPTH, 8, maximum outstanding requests; must be a power of two and ≥2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- issue_vld  input  1  arbitration accepted this cycle; push issue_port.
- issue_port  input  $clog2(PORT_NUM)  granted port index (the arbiter's arb_port).
- issue_rdy  output  1  tag FIFO not full; upstream ANDs this into its arbitration-round enable.
- rsp_vld  input  1  downstream response valid.
- rsp_data  input  DATA_WIDTH  downstream response payload.
- rsp_rdy  output  1  response accepted when rsp_vld && rsp_rdy.
- port_vld  output  PORT_NUM  one-hot; bit p means the response for port p is held.
- port_data  output  DATA_WIDTH  held payload, shared by all ports.
- port_rdy  input  PORT_NUM  per-port accept.
- outstanding  output  $clog2(DEPTH+1)  issued-but-unreturned count (FIFO occupancy plus held entry).
- err_ovf  output  1  sticky; set by issue_vld while full.

Behaviour:
- Reset (async, rst=1):
  - FIFO read/write pointers and count go to 0.
  - port_vld=0, port_data=0, outstanding=0, err_ovf=0.
  - issue_rdy=1, rsp_rdy=0.
  - Reset mid-transaction discards all tags and any held response without delivering them.
- Tag FIFO:
  - DEPTH entries of $clog2(PORT_NUM) bits; wr_ptr and rd_ptr wrap modulo DEPTH; occupancy counter `cnt` ranges 0..DEPTH.
  - Push on issue_vld && issue_rdy.
  - issue_rdy = (cnt != DEPTH), combinational from registered state only.
  - issue_vld while cnt==DEPTH: tag dropped, err_ovf<=1 (held until rst), pointers unchanged.
- Output stage, two states:
  - IDLE (port_vld==0):
    - rsp_rdy = (cnt != 0).
    - On acceptance: port_data<=rsp_data, port_vld<=1<<fifo[rd_ptr], rd_ptr++, cnt--, go to HOLD.
  - HOLD (port_vld!=0), with out_port = the index encoded in port_vld:
    - rsp_rdy = (cnt != 0) && port_rdy[out_port].
    - port_rdy[out_port]=1 with no new accept: port_vld<=0, go to IDLE.
    - port_rdy[out_port]=1 with a new accept in the same cycle: the output is reloaded back-to-back, state stays HOLD, no bubble.
    - port_rdy on non-target ports is ignored.
    - port_data and port_vld are stable while waiting.
- Latency: rsp accepted at cycle N appears on port_vld/port_data at N+1.
- Throughput: one response per cycle while the target ports keep port_rdy high.
- rsp_vld with cnt==0: not accepted (rsp_rdy=0), stalls indefinitely, no error flag.
- Simultaneous push and pop:
  - cnt unchanged, both pointers advance.
  - A tag pushed in cycle N is first poppable in N+1; rsp_rdy never uses issue_vld combinationally.
- outstanding = cnt + (port_vld != 0). Increments on push, decrements on port handshake; both in one cycle leaves it unchanged.
- issue_port >= PORT_NUM: behaviour undefined; the bench must not drive it.
- No combinational path from port_rdy to issue_rdy.
- Only combinational path into rsp_rdy: port_rdy[out_port].

Test Plan:
- Single round trip: reset; push port 5; rsp_vld with data 0xA5A5_0001 one cycle later; port_rdy=all 1 → port_vld=16'h0020 and port_data=0xA5A5_0001 at the next cycle; outstanding goes 1→1→0.
- In-order routing: push ports 3,0,15,3; responses D0..D3 back-to-back with port_rdy all 1 → port_vld sequence 0x0008, 0x0001, 0x8000, 0x0008 on consecutive cycles carrying D0..D3; no bubbles.
- Backpressure: hold for port 7 with port_rdy[7]=0 and other port_rdy bits=1 for 5 cycles → port_vld/port_data stable, rsp_rdy=0 with the next response waiting; raise port_rdy[7] → next response lands the following cycle.
- Full/overflow: push 8 tags with no responses → issue_rdy=0, outstanding=8; 9th issue_vld → err_ovf=1 and outstanding stays 8; drain all → issue_rdy=1, err_ovf stays 1.
- Empty and simultaneous push/pop: rsp_vld with no tags → rsp_rdy=0 and no port_vld. With cnt=2, push plus accept in the same cycle → cnt stays 2 and pointers wrap correctly across index 7→0.
- Async reset: assert rst mid-drain with port_vld=0x0004 and cnt=3 → all outputs reach reset values immediately, without waiting for a clock edge. After release, a fresh push of port 1 returns its response to port 1.
